// File: rtl/spi_flash_pkg.sv
// Shared definitions for the boot-flash SPI controllers: opcodes, sequencer
// states and the shift-engine transfer request.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam int STATUS_WIP_BIT   = 0;

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_PROG, S_POLL, S_GAP, S_DONE, S_ERROR
    } state_t;

    // Bits are MSB-aligned in data; nbits of them are shifted out.
    typedef struct packed {
        logic [39:0] data;
        logic [5:0]  nbits;
    } spi_xfer_t;

    function automatic spi_xfer_t make_xfer(state_t s, logic [15:0] a, logic [7:0] d);
        spi_xfer_t x;
        x.data  = '0;
        x.nbits = 6'd8;
        case (s)
            S_WREN: x.data = {CMD_WREN, 32'h0};
            S_PROG: begin
                x.data  = {CMD_PP, 8'h00, a, d};
                x.nbits = 6'd40;
            end
            S_POLL: begin
                x.data  = {CMD_RDSR, 32'h0};
                x.nbits = 6'd16;
            end
            default: ;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/spi_flash_writer_engine.sv
// SPI mode-0 bit engine: one CS-framed transfer of up to 40 bits, returning
// the last 8 bits seen on MISO. Shared with the flash read controller.
module spi_shift_engine
    import spi_flash_pkg::*;
#(
    parameter int HALF_PERIOD = 1
) (
    input  logic       clk,
    input  logic       i_RST_N,
    input  logic       i_START,
    input  spi_xfer_t  i_XFER,
    input  logic       i_MISO,
    output logic       o_SCK,
    output logic       o_MOSI,
    output logic       o_CS,
    output logic [7:0] o_RX,
    output logic       o_DONE
);
    localparam int DW = $clog2(HALF_PERIOD + 1);

    logic          r_active, r_sck, r_mosi, r_cs, r_tail, r_done;
    logic [DW-1:0] r_div;
    logic [5:0]    r_bitcnt;
    logic [39:0]   r_shift;
    logic [7:0]    r_rx;

    always_ff @(posedge clk) begin
        if (!i_RST_N) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_cs     <= 1'b1;
            r_tail   <= 1'b0;
            r_done   <= 1'b0;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_rx     <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (i_START) begin
                    r_active <= 1'b1;
                    r_cs     <= 1'b0;
                    r_shift  <= i_XFER.data;
                    r_mosi   <= i_XFER.data[39];
                    r_bitcnt <= i_XFER.nbits;
                    r_div    <= '0;
                    r_sck    <= 1'b0;
                    r_tail   <= 1'b0;
                end
            end else if (r_div != DW'(HALF_PERIOD - 1)) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div <= '0;
                if (r_tail) begin
                    // trailing low half-period done: close the frame
                    r_active <= 1'b0;
                    r_cs     <= 1'b1;
                    r_mosi   <= 1'b0;
                    r_done   <= 1'b1;
                    r_tail   <= 1'b0;
                end else if (!r_sck) begin
                    r_sck <= 1'b1;
                    r_rx  <= {r_rx[6:0], i_MISO};
                end else begin
                    r_sck    <= 1'b0;
                    r_bitcnt <= r_bitcnt - 6'd1;
                    r_shift  <= {r_shift[38:0], 1'b0};
                    r_mosi   <= r_shift[38];
                    if (r_bitcnt == 6'd1) r_tail <= 1'b1;
                end
            end
        end
    end

    assign o_SCK  = r_sck;
    assign o_MOSI = r_mosi;
    assign o_CS   = r_cs;
    assign o_RX   = r_rx;
    assign o_DONE = r_done;

endmodule

// File: rtl/spi_flash_writer.sv
// Programs one byte into the boot SPI flash per CPU write into the flash
// window: WREN, PAGE PROGRAM, then RDSR polling until WIP clears.
module spi_flash_writer
    import spi_flash_pkg::*;
#(
    parameter int HALF_PERIOD = 1,
    parameter int CS_GAP      = 4,
    parameter int POLL_LIMIT  = 65535
) (
    input  logic        clk,
    input  logic        i_RST_N,
    input  logic        spi_ce,
    input  logic        i_RW,
    input  logic [15:0] i_ADDRESS_BUS,
    input  logic [7:0]  i_DATA,
    input  logic        i_SPI_MISO,
    output logic        o_SPI_CLK,
    output logic        o_SPI_MOSI,
    output logic        o_SPI_CS,
    output logic        o_BUSY,
    output logic        o_ERROR
);
    localparam int GW = $clog2(CS_GAP + 1);

    state_t        r_state, r_next;
    spi_xfer_t     r_xfer;
    logic          r_req_d, r_start, r_wip, r_error;
    logic [15:0]   r_addr, r_poll_cnt;
    logic [7:0]    r_data;
    logic [GW-1:0] r_gap_cnt;

    logic       w_req, w_accept, w_done;
    logic [7:0] w_rx;
    logic [6:0] w_unused_status;

    assign w_req           = spi_ce && !i_RW;
    assign w_accept        = w_req && !r_req_d && (r_state == S_IDLE);
    assign w_unused_status = w_rx[7:1];

    spi_shift_engine #(.HALF_PERIOD(HALF_PERIOD)) u_engine (
        .clk     (clk),
        .i_RST_N (i_RST_N),
        .i_START (r_start),
        .i_XFER  (r_xfer),
        .i_MISO  (i_SPI_MISO),
        .o_SCK   (o_SPI_CLK),
        .o_MOSI  (o_SPI_MOSI),
        .o_CS    (o_SPI_CS),
        .o_RX    (w_rx),
        .o_DONE  (w_done)
    );

    always_ff @(posedge clk) begin
        if (!i_RST_N) begin
            r_state    <= S_IDLE;
            r_next     <= S_IDLE;
            r_xfer     <= '0;
            r_req_d    <= 1'b0;
            r_start    <= 1'b0;
            r_wip      <= 1'b0;
            r_error    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_poll_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_req_d <= w_req;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_addr     <= i_ADDRESS_BUS;
                    r_data     <= i_DATA;
                    r_error    <= 1'b0;
                    r_poll_cnt <= '0;
                    r_state    <= S_WREN;
                    r_start    <= 1'b1;
                    r_xfer     <= make_xfer(S_WREN, i_ADDRESS_BUS, i_DATA);
                end
                S_WREN, S_PROG, S_POLL: if (w_done) begin
                    r_state   <= S_GAP;
                    r_gap_cnt <= '0;
                    // S_DONE as the gap target means "decide from status"
                    r_next    <= (r_state == S_WREN) ? S_PROG :
                                 (r_state == S_PROG) ? S_POLL : S_DONE;
                    if (r_state == S_POLL) begin
                        r_wip <= w_rx[STATUS_WIP_BIT];
                        if (r_poll_cnt != 16'hFFFF) r_poll_cnt <= r_poll_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt != GW'(CS_GAP - 1)) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end else if (r_next != S_DONE) begin
                        r_state <= r_next;
                        r_start <= 1'b1;
                        r_xfer  <= make_xfer(r_next, r_addr, r_data);
                    end else if (!r_wip) begin
                        r_state <= S_DONE;
                    end else if (r_poll_cnt >= 16'(POLL_LIMIT)) begin
                        r_state <= S_ERROR;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= S_POLL;
                        r_start <= 1'b1;
                        r_xfer  <= make_xfer(S_POLL, r_addr, r_data);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_BUSY  = (r_state != S_IDLE);
    assign o_ERROR = r_error;

endmodule
